// File: rtl/c1541_track_stream_if.sv
// Track-buffer RAM port of the 1541 track streamer.
// buf_we is a single-cycle write strobe qualifying buf_addr/buf_dout in the same cycle; reads have no
// handshake: buf_din returns the byte at buf_addr one cycle later and the RAM never stalls.
interface c1541_track_stream_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_din;
  logic [7:0]        buf_dout;
  logic              buf_we;

  modport master (output buf_addr, output buf_dout, output buf_we, input buf_din);
  modport slave  (input buf_addr, input buf_dout, input buf_we, output buf_din);
endinterface

// File: rtl/c1541_track_stream.sv
// Rotating-media model: streams GCR bits from the track buffer at the zone bit rate, frames bytes
// relative to SYNC, and in write mode serializes dout back into the buffer.
module c1541_track_stream #(
  parameter int ADDR_W     = 13,
  parameter int BYTE_PULSE = 32
) (
  input  logic                 clk32,
  input  logic                 reset_n,
  input  logic                 mtr,
  input  logic [1:0]           freq,
  input  logic                 mode,
  input  logic [7:0]           dout,
  input  logic                 wprot,
  input  logic [ADDR_W-1:0]    track_len,
  output logic [7:0]           din,
  output logic                 sync_n,
  output logic                 byte_n,
  output logic                 dirty,
  input  logic                 dirty_clr,
  c1541_track_stream_if.master bus
);

  localparam int PW = $clog2(BYTE_PULSE + 1);

  logic [6:0]        div, per, per_sel;
  logic              tick, boundary, rd_tick, wr_tick;
  logic [2:0]        bit_idx;
  logic [ADDR_W-1:0] pos, pos_inc;
  logic [ADDR_W:0]   pos_p1;
  logic              adv;
  logic [1:0]        ld_q;
  logic [7:0]        cur_byte;
  logic [9:0]        rsr, rsr_d;
  logic [2:0]        fcnt, fcnt_d;
  logic [7:0]        din_d, wsr, wsr_d, wbyte, wbyte_d, wdata, wdata_d;
  logic              we_q, we_d, start;
  logic [PW-1:0]     pcnt;

  // Period minus one; latched only at a reload so a zone change never shortens the running interval.
  assign per_sel  = 7'd127 - {2'b00, freq, 3'b000};
  assign tick     = mtr & (div == per);
  assign boundary = tick & (bit_idx == 3'd7);
  assign rd_tick  = tick & mode;
  assign wr_tick  = tick & ~mode;

  assign pos_p1  = {1'b0, pos} + {{ADDR_W{1'b0}}, 1'b1};
  assign pos_inc = (pos_p1 >= {1'b0, track_len}) ? '0 : pos_p1[ADDR_W-1:0];

  assign bus.buf_addr = pos;
  assign bus.buf_dout = wdata;
  assign bus.buf_we   = we_q;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      per <= 7'd127;
    end else if (!mtr || tick) begin
      div <= '0;
      per <= per_sel;
    end else begin
      div <= div + 7'd1;
    end
  end

  // pos advances the cycle after the byte boundary so a write strobe still sees the old address.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx  <= '0;
      pos      <= '0;
      adv      <= 1'b0;
      ld_q     <= 2'b01;
      cur_byte <= '0;
    end else begin
      if (tick) bit_idx <= bit_idx + 3'd1;
      adv  <= boundary;
      if (adv) pos <= pos_inc;
      ld_q <= {ld_q[0], adv};
      if (ld_q[1]) cur_byte <= bus.buf_din;
    end
  end

  always_comb begin
    rsr_d   = rsr;
    fcnt_d  = fcnt;
    din_d   = din;
    wsr_d   = wsr;
    wbyte_d = wbyte;
    wdata_d = wdata;
    we_d    = 1'b0;
    start   = 1'b0;
    if (rd_tick) begin
      rsr_d = {rsr[8:0], cur_byte[~bit_idx]};
      if (rsr_d == 10'h3FF) begin
        fcnt_d = '0;
      end else if (rsr == 10'h3FF) begin
        fcnt_d = 3'd1;
      end else if (fcnt == 3'd7) begin
        fcnt_d = '0;
        din_d  = rsr_d[7:0];
        start  = 1'b1;
      end else begin
        fcnt_d = fcnt + 3'd1;
      end
    end else if (wr_tick) begin
      rsr_d   = '0;
      fcnt_d  = '0;
      wbyte_d = {wbyte[6:0], wsr[7]};
      wsr_d   = boundary ? dout : {wsr[6:0], 1'b0};
      if (boundary) begin
        wdata_d = wbyte_d;
        we_d    = ~wprot;
        start   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      rsr    <= '0;
      fcnt   <= '0;
      din    <= '0;
      wsr    <= '0;
      wbyte  <= '0;
      wdata  <= '0;
      we_q   <= 1'b0;
      sync_n <= 1'b1;
      dirty  <= 1'b0;
      byte_n <= 1'b1;
      pcnt   <= '0;
    end else begin
      rsr    <= rsr_d;
      fcnt   <= fcnt_d;
      din    <= din_d;
      wsr    <= wsr_d;
      wbyte  <= wbyte_d;
      wdata  <= wdata_d;
      we_q   <= we_d;
      sync_n <= ~(mtr & mode & (rsr_d == 10'h3FF));
      if (we_d) dirty <= 1'b1;
      else if (dirty_clr) dirty <= 1'b0;
      // Pulse timer keeps running with the motor off so an active pulse always completes.
      if (start) begin
        byte_n <= 1'b0;
        pcnt   <= PW'(BYTE_PULSE - 1);
      end else if (pcnt != '0) begin
        pcnt <= pcnt - PW'(1);
      end else begin
        byte_n <= 1'b1;
      end
    end
  end

endmodule
